// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline-control types for the decode hazard unit.
// Provides:
// - the register index type;
// - the writer class enum;
// - the scoreboard slot record;
// - the default multi-cycle latency;
// - a helper that tells whether a slot writes a given register.
package hazard_ctrl_pkg;

  localparam int unsigned NREG_BITS         = 5;
  localparam int unsigned MULTI_LAT_DEFAULT = 4;

  typedef logic [NREG_BITS-1:0] creg_addr_t;

  typedef enum logic [1:0] {
    KIND_ALU   = 2'd0,
    KIND_LOAD  = 2'd1,
    KIND_MULTI = 2'd2,
    KIND_NONE  = 2'd3
  } writer_kind_t;

  typedef struct packed {
    logic         valid;
    creg_addr_t   dst;
    logic         regwrite;
    writer_kind_t kind;
  } sb_slot_t;

  localparam sb_slot_t SLOT_BUBBLE = '{
    valid:    1'b0,
    dst:      {NREG_BITS{1'b0}},
    regwrite: 1'b0,
    kind:     KIND_NONE
  };

  // x0 is hardwired, so a slot targeting it never produces a value anyone waits for.
  function automatic logic slot_writes(input sb_slot_t s, input creg_addr_t r);
    return s.valid && s.regwrite && (s.dst != {NREG_BITS{1'b0}}) && (s.dst == r);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-stage <-> hazard unit bundle.
// master: the decode stage.
//   - Drives the instruction fields and branch_taken.
//   - Receives the stall, flush and forward controls.
// slave: the hazard unit.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  logic         id_valid;
  creg_addr_t   id_rs1;
  creg_addr_t   id_rs2;
  logic         id_use_rs1;
  logic         id_use_rs2;
  creg_addr_t   id_dst;
  logic         id_regwrite;
  writer_kind_t id_kind;
  logic         branch_taken;

  logic         stall_f;
  logic         stall_d;
  logic         flush_d;
  logic         fwd_valid_a;
  logic         fwd_valid_b;
  logic         ex_busy;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_dst, id_regwrite, id_kind, branch_taken,
    input  stall_f, stall_d, flush_d, fwd_valid_a, fwd_valid_b, ex_busy
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_dst, id_regwrite, id_kind, branch_taken,
    output stall_f, stall_d, flush_d, fwd_valid_a, fwd_valid_b, ex_busy
  );

endinterface

// File: rtl/hazard_ctrl_match.sv
// hazard_match: per-source RAW check against the EX/MEM/WB shadow slots.
// Ports:
// - src, use_src: register read by decode, and whether that read is real.
//   The caller folds id_valid into use_src.
// - ex_slot, mem_slot, wb_slot: shadow of the in-flight destinations.
// - ex_busy: a multi-cycle op is still occupying EX.
// - fwd: take the EX ALU result instead of the regfile.
// - stall: the value is not yet obtainable.
module hazard_match
  import hazard_ctrl_pkg::*;
(
  input  creg_addr_t src,
  input  logic       use_src,
  input  sb_slot_t   ex_slot,
  input  sb_slot_t   mem_slot,
  input  sb_slot_t   wb_slot,
  input  logic       ex_busy,
  output logic       fwd,
  output logic       stall
);

  // Youngest writer wins: only an idle ALU result in EX can be forwarded.
  // Anything older has no bypass path and must be waited out.
  always_comb begin
    fwd   = 1'b0;
    stall = 1'b0;
    if (use_src && (src != {NREG_BITS{1'b0}})) begin
      if (slot_writes(ex_slot, src)) begin
        if ((ex_slot.kind == KIND_ALU) && !ex_busy) begin
          fwd = 1'b1;
        end else begin
          stall = 1'b1;
        end
      end else if (slot_writes(mem_slot, src) || slot_writes(wb_slot, src)) begin
        stall = 1'b1;
      end else begin
        fwd   = 1'b0;
        stall = 1'b0;
      end
    end else begin
      fwd   = 1'b0;
      stall = 1'b0;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: decode-stage sequencing (forwarding select, stall, flush).
// State:
// - a 3-slot shadow of the EX/MEM/WB destination registers;
// - a busy counter that holds EX for multi-cycle ops.
// Ports:
// - clk, reset: clock and asynchronous active-high reset.
// - hz: the slave side of hazard_ctrl_if (decode fields in, controls out).
// All outputs are combinational from the state and the decode-side inputs.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MULTI_LAT = MULTI_LAT_DEFAULT
)(
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hz
);

  localparam int unsigned CNT_W = (MULTI_LAT > 1) ? $clog2(MULTI_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // The first EX cycle is the advance itself, so only the remaining cycles are counted.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULTI_LAT - 1);

  sb_slot_t         ex_q, ex_d;
  sb_slot_t         mem_q, mem_d;
  sb_slot_t         wb_q, wb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  sb_slot_t id_slot_s;
  logic     ex_busy_s;
  logic     fwd_a_s, fwd_b_s;
  logic     stall_a_s, stall_b_s;
  logic     raw_stall_s;
  logic     redirect_s;
  logic     stall_s;
  logic     flush_s;

  assign ex_busy_s = (cnt_q != CNT_ZERO);

  assign id_slot_s = '{
    valid:    1'b1,
    dst:      hz.id_dst,
    regwrite: hz.id_regwrite,
    kind:     hz.id_kind
  };

  hazard_match u_match_a (
    .src      (hz.id_rs1),
    .use_src  (hz.id_valid && hz.id_use_rs1),
    .ex_slot  (ex_q),
    .mem_slot (mem_q),
    .wb_slot  (wb_q),
    .ex_busy  (ex_busy_s),
    .fwd      (fwd_a_s),
    .stall    (stall_a_s)
  );

  hazard_match u_match_b (
    .src      (hz.id_rs2),
    .use_src  (hz.id_valid && hz.id_use_rs2),
    .ex_slot  (ex_q),
    .mem_slot (mem_q),
    .wb_slot  (wb_q),
    .ex_busy  (ex_busy_s),
    .fwd      (fwd_b_s),
    .stall    (stall_b_s)
  );

  // Pipeline control.
  // - A branch cannot sit in EX behind a busy op, so the redirect is gated by ex_busy.
  // - A redirect overrides any stall: decode is discarded, so holding fetch is pointless.
  // - While EX is busy, decode just holds; no bubble is pushed into the occupied EX.
  always_comb begin
    raw_stall_s = stall_a_s || stall_b_s;
    redirect_s  = hz.branch_taken && !ex_busy_s;
    stall_s     = (raw_stall_s || ex_busy_s) && !redirect_s;
    flush_s     = redirect_s || (raw_stall_s && !ex_busy_s);
  end

  assign hz.stall_f     = stall_s;
  assign hz.stall_d     = stall_s;
  assign hz.flush_d     = flush_s;
  assign hz.fwd_valid_a = fwd_a_s;
  assign hz.fwd_valid_b = fwd_b_s;
  assign hz.ex_busy     = ex_busy_s;

  // Next shadow state.
  // - Busy: the multi-cycle op stays in EX and a bubble drains into MEM.
  // - Otherwise: the shadow advances, and EX takes the decode fields only when
  //   decode has a valid instruction and is not flushed.
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    cnt_d = cnt_q;
    if (ex_busy_s) begin
      cnt_d = cnt_q - CNT_ONE;
      mem_d = SLOT_BUBBLE;
      wb_d  = mem_q;
    end else begin
      mem_d = ex_q;
      wb_d  = mem_q;
      if (flush_s || !hz.id_valid) begin
        ex_d  = SLOT_BUBBLE;
        cnt_d = CNT_ZERO;
      end else begin
        ex_d = id_slot_s;
        if (hz.id_kind == KIND_MULTI) begin
          cnt_d = CNT_LOAD;
        end else begin
          cnt_d = CNT_ZERO;
        end
      end
    end
  end

  // Shadow slots and busy counter; reset empties the pipeline immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q  <= SLOT_BUBBLE;
      mem_q <= SLOT_BUBBLE;
      wb_q  <= SLOT_BUBBLE;
      cnt_q <= CNT_ZERO;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl.
// - Each stimulus cycle pushes the hand-derived control vector for that cycle.
// - The scoreboard process pops and compares it on the following negedge.
// Vector layout: {stall_f, stall_d, flush_d, fwd_valid_a, fwd_valid_b, ex_busy}.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  typedef struct {
    string      tag;
    logic [5:0] exp;
  } sb_entry_t;

  logic clk;
  logic reset;
  int   err_cnt;
  int   chk_cnt;
  sb_entry_t sb_q[$];
  sb_entry_t sb_e;

  hazard_ctrl_if hz_if ();

  hazard_ctrl #(.MULTI_LAT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1);
  end

  function automatic logic [5:0] obs_vec();
    return {hz_if.stall_f, hz_if.stall_d, hz_if.flush_d,
            hz_if.fwd_valid_a, hz_if.fwd_valid_b, hz_if.ex_busy};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%b exp=%b", tag, got[5:0], exp[5:0]);
    end
  endtask

  task automatic set_in(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] dst,
                        input logic rw, input writer_kind_t k, input logic br);
    hz_if.id_valid     = v;
    hz_if.id_rs1       = rs1;
    hz_if.id_rs2       = rs2;
    hz_if.id_use_rs1   = u1;
    hz_if.id_use_rs2   = u2;
    hz_if.id_dst       = dst;
    hz_if.id_regwrite  = rw;
    hz_if.id_kind      = k;
    hz_if.branch_taken = br;
  endtask

  // One decode cycle: drive just after the edge, queue what the outputs must be.
  task automatic cyc(input string tag, input logic v, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic u1, input logic u2,
                     input logic [4:0] dst, input logic rw, input writer_kind_t k,
                     input logic br, input logic [5:0] exp);
    sb_entry_t e;
    @(posedge clk);
    #1;
    set_in(v, rs1, rs2, u1, u2, dst, rw, k, br);
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic idle(input string tag, input logic [5:0] exp);
    cyc(tag, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, KIND_NONE, 1'b0, exp);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 3; i++) idle(tag, 6'b000000);
  endtask

  // Scoreboard: compare the queued expectation against the settled outputs.
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      sb_e = sb_q.pop_front();
      check_eq(sb_e.tag, {26'd0, obs_vec()}, {26'd0, sb_e.exp});
    end
  end

  initial begin
    err_cnt = 0;
    chk_cnt = 0;
    reset   = 1'b1;
    set_in(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, KIND_ALU, 1'b0);
    #2;
    check_eq("reset_outs", {26'd0, obs_vec()}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // ALU forwarding, including youngest-writer priority (EX over MEM/WB).
    cyc("t1_add5",  1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, KIND_ALU, 1'b0, 6'b000000);
    cyc("t1_sub",   1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, KIND_ALU, 1'b0, 6'b000100);
    cyc("t1_add5b", 1'b1, 5'd6, 5'd0, 1'b1, 1'b1, 5'd5, 1'b1, KIND_ALU, 1'b0, 6'b000100);
    cyc("t1_young", 1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd7, 1'b1, KIND_ALU, 1'b0, 6'b000110);
    drain("t1_drain");

    // An ALU result that already reached MEM/WB cannot be forwarded.
    cyc("t1m_add11", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd11, 1'b1, KIND_ALU, 1'b0, 6'b000000);
    idle("t1m_gap", 6'b000000);
    cyc("t1m_mem",  1'b1, 5'd11, 5'd0, 1'b1, 1'b0, 5'd12, 1'b1, KIND_ALU, 1'b0, 6'b111000);
    cyc("t1m_wb",   1'b1, 5'd11, 5'd0, 1'b1, 1'b0, 5'd12, 1'b1, KIND_ALU, 1'b0, 6'b111000);
    cyc("t1m_go",   1'b1, 5'd11, 5'd0, 1'b1, 1'b0, 5'd12, 1'b1, KIND_ALU, 1'b0, 6'b000000);
    drain("t1m_drain");

    // Load-use: stall while the load is in EX, MEM and WB, then proceed from the regfile.
    cyc("t2_lw",    1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, KIND_LOAD, 1'b0, 6'b000000);
    cyc("t2_ex",    1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, KIND_ALU,  1'b0, 6'b111000);
    cyc("t2_mem",   1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, KIND_ALU,  1'b0, 6'b111000);
    cyc("t2_wb",    1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, KIND_ALU,  1'b0, 6'b111000);
    cyc("t2_go",    1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, KIND_ALU,  1'b0, 6'b000000);
    drain("t2_drain");

    // Multi-cycle op: 3 busy cycles (branch ignored in one), then 3 RAW stall cycles.
    cyc("t3_mul",   1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd9,  1'b1, KIND_MULTI, 1'b0, 6'b000000);
    cyc("t3_busy1", 1'b1, 5'd9, 5'd0, 1'b1, 1'b1, 5'd10, 1'b1, KIND_ALU,   1'b0, 6'b110001);
    cyc("t3_busy2", 1'b1, 5'd9, 5'd0, 1'b1, 1'b1, 5'd10, 1'b1, KIND_ALU,   1'b1, 6'b110001);
    cyc("t3_busy3", 1'b1, 5'd9, 5'd0, 1'b1, 1'b1, 5'd10, 1'b1, KIND_ALU,   1'b0, 6'b110001);
    cyc("t3_raw_ex",  1'b1, 5'd9, 5'd0, 1'b1, 1'b1, 5'd10, 1'b1, KIND_ALU, 1'b0, 6'b111000);
    cyc("t3_raw_mem", 1'b1, 5'd9, 5'd0, 1'b1, 1'b1, 5'd10, 1'b1, KIND_ALU, 1'b0, 6'b111000);
    cyc("t3_raw_wb",  1'b1, 5'd9, 5'd0, 1'b1, 1'b1, 5'd10, 1'b1, KIND_ALU, 1'b0, 6'b111000);
    cyc("t3_go",      1'b1, 5'd9, 5'd0, 1'b1, 1'b1, 5'd10, 1'b1, KIND_ALU, 1'b0, 6'b000000);
    drain("t3_drain");

    // Redirect beats a load-use stall; the flushed add must not appear in EX.
    cyc("t4_lw",    1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7,  1'b1, KIND_LOAD, 1'b0, 6'b000000);
    cyc("t4_redir", 1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8,  1'b1, KIND_ALU,  1'b1, 6'b001000);
    cyc("t4_exinv", 1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 5'd13, 1'b1, KIND_ALU,  1'b0, 6'b000000);
    cyc("t4_br",    1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b0, KIND_NONE, 1'b1, 6'b001000);
    drain("t4_drain");

    // x0 is never a hazard; unused sources and invalid decode are never checked.
    cyc("t5_addx0", 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, KIND_ALU, 1'b0, 6'b000000);
    cyc("t5_rdx0",  1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd1, 1'b1, KIND_ALU, 1'b0, 6'b000000);
    cyc("t5_nouse", 1'b1, 5'd3, 5'd1, 1'b1, 1'b0, 5'd4, 1'b1, KIND_ALU, 1'b0, 6'b000000);
    cyc("t5_inval", 1'b0, 5'd4, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, KIND_ALU, 1'b0, 6'b000000);
    drain("t5_drain");

    // Asynchronous reset while the mul still has 2 hold cycles left.
    cyc("t6_mul",   1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd9, 1'b1, KIND_MULTI, 1'b0, 6'b000000);
    idle("t6_busy3", 6'b110001);
    idle("t6_busy2", 6'b110001);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_eq("t6_rst_busy", {31'd0, hz_if.ex_busy}, 32'd0);
    check_eq("t6_rst_outs", {26'd0, obs_vec()}, 32'd0);
    set_in(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd14, 1'b1, KIND_ALU, 1'b0);
    #1;
    check_eq("t6_rst_clear", {26'd0, obs_vec()}, 32'd0);
    @(posedge clk);
    #1;
    check_eq("t6_rst_hold", {26'd0, obs_vec()}, 32'd0);
    @(negedge clk);
    set_in(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, KIND_ALU, 1'b0);
    reset = 1'b0;
    idle("t6_post_idle", 6'b000000);
    cyc("t6_post_rd", 1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd14, 1'b1, KIND_ALU, 1'b0, 6'b000000);

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    #1;
    check_eq("sb_drain", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
